core_io_port: RTL and testbench

//  Memory-mapped IO peripheral between the RV32I core's load/store port and the board pins.

---
 rtl/core_io_port.sv | 155 +++++++++++++++
 tb/tb_core_io_port.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/core_io_port.sv
// Memory-mapped IO peripheral for the RV32I load/store port: synchronised, debounced
// inputs with sticky rising-edge flags and interrupt, plus byte-writable output registers.
module core_io_port #(
    parameter int                   IN_WIDTH        = 14,
    parameter int                   OUT_WIDTH       = 52,
    parameter int                   DEBOUNCE_CYCLES = 4,
    parameter int                   ADDR_W          = 4,
    parameter logic [OUT_WIDTH-1:0] RESET_OUT       = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [ADDR_W-1:0]    bus_addr,
    input  logic                 bus_we,
    input  logic                 bus_re,
    input  logic [31:0]          bus_wdata,
    input  logic [3:0]           bus_wstrb,
    output logic [31:0]          bus_rdata,
    output logic                 bus_rvalid,
    input  logic [IN_WIDTH-1:0]  io_input_bus,
    output logic [OUT_WIDTH-1:0] io_output_bus,
    output logic                 irq
);

    localparam int OW      = (OUT_WIDTH + 31) / 32;
    localparam int OUT_PAD = OW * 32;

    logic [IN_WIDTH-1:0]  sync1_q, sync2_q;
    logic [IN_WIDTH-1:0]  deb_q, deb_d;
    logic [IN_WIDTH-1:0]  edge_q, edge_d;
    logic [IN_WIDTH-1:0]  irqEn_q, irqEn_d;
    logic [OUT_WIDTH-1:0] out_q, out_d;
    logic [OUT_PAD-1:0]   outWrite, outRead;
    logic [31:0]          rdata_q, rdata_d;
    logic                 rvalid_q, irq_q;
    logic [31:0]          byteMask, wMasked;
    logic                 wrEdge, wrIrqEn;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= io_input_bus;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_comb deb_d = sync2_q;
        end else begin : g_debounce
            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
            logic [CNT_W-1:0] cnt_q [IN_WIDTH];
            logic [CNT_W-1:0] cnt_d [IN_WIDTH];

            // A mismatch must persist for DEBOUNCE_CYCLES consecutive edges before it is accepted.
            always_comb begin
                for (int i = 0; i < IN_WIDTH; i++) begin
                    deb_d[i] = deb_q[i];
                    cnt_d[i] = '0;
                    if (sync2_q[i] != deb_q[i]) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            deb_d[i] = sync2_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + 1'b1;
                        end
                    end
                end
            end

            always_ff @(posedge clock) begin
                for (int i = 0; i < IN_WIDTH; i++) begin
                    if (reset) begin
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_d[i];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        byteMask = {{8{bus_wstrb[3]}}, {8{bus_wstrb[2]}}, {8{bus_wstrb[1]}}, {8{bus_wstrb[0]}}};
        wMasked  = bus_wdata & byteMask;
        wrEdge   = bus_we && (bus_addr == ADDR_W'(1));
        wrIrqEn  = bus_we && (bus_addr == ADDR_W'(2));
    end

    // A new rising edge is OR-ed in after the W1C clear, so set beats clear.
    always_comb begin
        edge_d  = edge_q;
        irqEn_d = irqEn_q;
        if (wrEdge) begin
            edge_d = edge_q & ~wMasked[IN_WIDTH-1:0];
        end
        edge_d = edge_d | (deb_d & ~deb_q);
        if (wrIrqEn) begin
            irqEn_d = (irqEn_q & ~byteMask[IN_WIDTH-1:0]) | wMasked[IN_WIDTH-1:0];
        end
    end

    always_comb begin
        outRead  = OUT_PAD'(out_q);
        outWrite = outRead;
        for (int w = 0; w < OW; w++) begin
            if (bus_we && (bus_addr == ADDR_W'(4 + w))) begin
                outWrite[w*32 +: 32] = (outRead[w*32 +: 32] & ~byteMask) | wMasked;
            end
        end
        out_d = outWrite[OUT_WIDTH-1:0];
    end

    always_comb begin
        rdata_d = '0;
        if (bus_addr == ADDR_W'(0)) rdata_d = 32'(deb_q);
        if (bus_addr == ADDR_W'(1)) rdata_d = 32'(edge_q);
        if (bus_addr == ADDR_W'(2)) rdata_d = 32'(irqEn_q);
        for (int w = 0; w < OW; w++) begin
            if (bus_addr == ADDR_W'(4 + w)) begin
                rdata_d = outRead[w*32 +: 32];
            end
        end
    end

    // Reads sample the pre-edge register contents, so a same-cycle write is not visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            deb_q    <= '0;
            edge_q   <= '0;
            irqEn_q  <= '0;
            out_q    <= RESET_OUT;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            deb_q    <= deb_d;
            edge_q   <= edge_d;
            irqEn_q  <= irqEn_d;
            out_q    <= out_d;
            rvalid_q <= bus_re;
            irq_q    <= |(edge_q & irqEn_q);
            if (bus_re) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign bus_rdata     = rdata_q;
    assign bus_rvalid    = rvalid_q;
    assign io_output_bus = out_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_core_io_port.sv
// Scoreboard bench for core_io_port: reads push expected data, a negedge monitor
// pops and compares on every bus_rvalid pulse; pin-level outputs are checked directly.
module tb_core_io_port;

    localparam int IN_WIDTH  = 14;
    localparam int OUT_WIDTH = 52;
    localparam int ADDR_W    = 4;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [ADDR_W-1:0]    bus_addr;
    logic                 bus_we;
    logic                 bus_re;
    logic [31:0]          bus_wdata;
    logic [3:0]           bus_wstrb;
    logic [31:0]          bus_rdata;
    logic                 bus_rvalid;
    logic [IN_WIDTH-1:0]  io_input_bus;
    logic [OUT_WIDTH-1:0] io_output_bus;
    logic                 irq;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [31:0] expQ[$];
    string       nameQ[$];

    always #5 clock = ~clock;

    core_io_port #(
        .IN_WIDTH       (IN_WIDTH),
        .OUT_WIDTH      (OUT_WIDTH),
        .DEBOUNCE_CYCLES(4),
        .ADDR_W         (ADDR_W),
        .RESET_OUT      (52'hA5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .bus_addr     (bus_addr),
        .bus_we       (bus_we),
        .bus_re       (bus_re),
        .bus_wdata    (bus_wdata),
        .bus_wstrb    (bus_wstrb),
        .bus_rdata    (bus_rdata),
        .bus_rvalid   (bus_rvalid),
        .io_input_bus (io_input_bus),
        .io_output_bus(io_output_bus),
        .irq          (irq)
    );

    // Monitor: every read response must match the oldest outstanding expectation.
    always @(negedge clock) begin
        logic [31:0] exp;
        string       nm;
        if (bus_rvalid) begin
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpectedRvalid: rdata=%h with no read outstanding", bus_rdata);
            end else begin
                exp = expQ.pop_front();
                nm  = nameQ.pop_front();
                if (bus_rdata !== exp) begin
                    miscompares++;
                    $display("[TB] FAIL %s: got %h, expected %h", nm, bus_rdata, exp);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic we, input logic re,
                                 input logic [31:0] wdata, input logic [3:0] strb);
        bus_addr  = addr;
        bus_we    = we;
        bus_re    = re;
        bus_wdata = wdata;
        bus_wstrb = strb;
        @(posedge clock);
        #1;
        bus_we = 1'b0;
        bus_re = 1'b0;
    endtask

    task automatic busWrite(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
        applyStimulus(addr, 1'b1, 1'b0, data, strb);
    endtask

    task automatic busRead(input string nm, input logic [ADDR_W-1:0] addr, input logic [31:0] expected);
        expQ.push_back(expected);
        nameQ.push_back(nm);
        applyStimulus(addr, 1'b0, 1'b1, 32'h0, 4'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string nm, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", nm, actual, expected);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus_addr     = '0;
        bus_we       = 1'b0;
        bus_re       = 1'b0;
        bus_wdata    = '0;
        bus_wstrb    = '0;
        io_input_bus = '0;
        idle(3);

        // Reset state and readback of every mapped index.
        checkOutput("resetOut", 64'(io_output_bus), 64'hA5);
        checkOutput("resetRvalid", 64'(bus_rvalid), 64'h0);
        checkOutput("resetIrq", 64'(irq), 64'h0);
        reset = 1'b0;
        busRead("rstInState", 4'd0, 32'h0);
        busRead("rstEdge", 4'd1, 32'h0);
        busRead("rstIrqEn", 4'd2, 32'h0);
        busRead("rstReserved", 4'd3, 32'h0);
        busRead("rstOut0", 4'd4, 32'h0000_00A5);
        busRead("rstOut1", 4'd5, 32'h0);

        // Byte-strobed output writes and readback; upper word has only 20 live bits.
        busWrite(4'd4, 32'h1234_5678, 4'b0101);
        checkOutput("outStrobe", 64'(io_output_bus), 64'h0034_0078);
        busRead("readOut0", 4'd4, 32'h0034_0078);
        busWrite(4'd5, 32'hFFFF_FFFF, 4'hF);
        checkOutput("outUpper", 64'(io_output_bus), 64'h000F_FFFF_0034_0078);
        busRead("readOut1", 4'd5, 32'h000F_FFFF);

        // Debounce latency on bit 3 with interrupt enabled.
        busWrite(4'd2, 32'h0000_0008, 4'hF);
        io_input_bus[3] = 1'b1;
        idle(5);
        busRead("inStateEdge6", 4'd0, 32'h0);
        checkOutput("irqBeforeEdge", 64'(irq), 64'h0);
        busRead("inStateEdge7", 4'd0, 32'h8);
        checkOutput("irqAfterEdge", 64'(irq), 64'h1);

        // Three-cycle glitch on bit 2 must be filtered out.
        io_input_bus[2] = 1'b1;
        idle(3);
        io_input_bus[2] = 1'b0;
        idle(10);
        busRead("glitchInState", 4'd0, 32'h8);
        busRead("glitchEdge", 4'd1, 32'h8);

        // W1C clears EDGE; irq follows one cycle later.
        busWrite(4'd1, 32'h0000_0008, 4'hF);
        checkOutput("irqHoldAfterW1C", 64'(irq), 64'h1);
        idle(1);
        checkOutput("irqDropAfterW1C", 64'(irq), 64'h0);
        busRead("edgeCleared", 4'd1, 32'h0);

        // Falling edge updates IN_STATE but not EDGE.
        io_input_bus[3] = 1'b0;
        idle(8);
        busRead("fallInState", 4'd0, 32'h0);
        busRead("fallEdge", 4'd1, 32'h0);

        // W1C coinciding with a fresh debounced rise: the set wins.
        io_input_bus[3] = 1'b1;
        idle(5);
        busWrite(4'd1, 32'h0000_0008, 4'hF);
        busRead("setWinsEdge", 4'd1, 32'h8);
        checkOutput("setWinsIrq", 64'(irq), 64'h1);
        io_input_bus[3] = 1'b0;
        idle(8);

        // Read-during-write, field truncation, unmapped and reserved indexes.
        expQ.push_back(32'h8);
        nameQ.push_back("rdDuringWr");
        applyStimulus(4'd2, 1'b1, 1'b1, 32'h0000_000F, 4'hF);
        busRead("afterWr", 4'd2, 32'h0000_000F);
        busWrite(4'd2, 32'hFFFF_FFFF, 4'hF);
        busRead("irqEnTrunc", 4'd2, 32'h0000_3FFF);
        busRead("unmapped15", 4'd15, 32'h0);
        busWrite(4'd3, 32'hFFFF_FFFF, 4'hF);
        busRead("reservedWr", 4'd3, 32'h0);
        checkOutput("irqBeforeReset", 64'(irq), 64'h1);

        // Reset together with a read strobe: no response may appear.
        reset = 1'b1;
        applyStimulus(4'd4, 1'b0, 1'b1, 32'h0, 4'h0);
        checkOutput("abortRvalid", 64'(bus_rvalid), 64'h0);
        idle(1);
        reset = 1'b0;
        checkOutput("reResetOut", 64'(io_output_bus), 64'hA5);
        checkOutput("reResetIrq", 64'(irq), 64'h0);
        busRead("reResetEdge", 4'd1, 32'h0);
        busRead("reResetIrqEn", 4'd2, 32'h0);

        idle(3);
        checkOutput("pendingReads", 64'(expQ.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
